// File: rtl/leb128_pkg.sv
// Shared types for the LEB128 immediate decoder: FSM states, trap codes, length limits,
// and the optional strict-mode check (LEB128_STRICT_EN).
package leb128_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } state_e;

   // NO_64B keeps the numeric code the core already decodes.
   typedef enum logic [3:0] {
      NONE      = 4'd0,
      TOO_LONG  = 4'd1,
      MEM_ERROR = 4'd2,
      NO_64B    = 4'd3,
      OVERLONG  = 4'd4
   } trap_e;

   localparam int unsigned MAX_LEN32 = 5;
   localparam int unsigned MAX_LEN64 = 10;

   // Final byte of a max-length encoding: bits above the target width must be pure extension.
   function automatic logic strict_violation(input logic [7:0] b,
                                             input logic       is_signed,
                                             input logic       is64);
      if (is64) begin
         return b[6:1] != {6{is_signed & b[0]}};
      end
      return b[6:4] != {3{is_signed & b[3]}};
   endfunction

endpackage

// File: rtl/leb128_byte_merge.sv
// Combinational step of the decoder: folds one encoded byte into the accumulator and
// produces the sign/zero-extended result assuming this byte is the last one.
module leb128_byte_merge
   import leb128_pkg::*;
(
   input  logic [63:0] acc,
   input  logic [7:0]  data,
   input  logic [3:0]  k,
   input  logic        is_signed,
   input  logic        is64,
   output logic [63:0] next_acc,
   output logic        last,
   output logic [63:0] ext_value
);

   logic [6:0]  shamt;
   logic [7:0]  fill_pos;
   logic [63:0] filled;

   always_comb begin
      shamt    = {3'b000, k} * 7'd7;
      fill_pos = ({4'b0000, k} * 8'd7) + 8'd7;
      // The 64-bit shift drops payload bits that land above bit 63 on the 10th byte.
      next_acc = acc | ({57'd0, data[6:0]} << shamt);
      last     = ~data[7];
      filled   = next_acc;
      if (is_signed && data[6] && (fill_pos < 8'd64)) begin
         filled = next_acc | (64'hFFFF_FFFF_FFFF_FFFF << fill_pos);
      end
      if (is64) begin
         ext_value = filled;
      end else begin
         ext_value = {(is_signed ? {32{filled[31]}} : 32'd0), filled[31:0]};
      end
   end

endmodule

// File: rtl/leb128_decoder.sv
// Byte-serial LEB128 immediate decoder (ROM -> core). Strict overlong checking of the
// final byte is enabled by defining LEB128_STRICT_EN.
module leb128_decoder
   import leb128_pkg::*;
#(
   parameter int MEM_DEPTH = 6,
   parameter int MEM_EXTRA = 4,
   parameter int USE_64B   = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [MEM_DEPTH:0]   start_addr,
   input  logic                 is_signed,
   input  logic                 is64,
   output logic [MEM_DEPTH:0]   mem_addr,
   output logic [MEM_EXTRA-1:0] mem_extra,
   input  logic [7:0]           mem_data,
   input  logic                 mem_error,
   output logic                 busy,
   output logic                 done,
   output logic [63:0]          value,
   output logic [3:0]           length,
   output logic [3:0]           trap
);

   state_e             state_q, state_d;
   logic [MEM_DEPTH:0] addr_q, addr_d;
   logic [3:0]         k_q, k_d, length_q, length_d, max_idx;
   logic [63:0]        acc_q, acc_d, value_q, value_d, next_acc, ext_value;
   logic               signed_q, signed_d, is64_q, is64_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic               last, overlong;
   trap_e              trap_q, trap_d;

   leb128_byte_merge u_merge (
      .acc       (acc_q),
      .data      (mem_data),
      .k         (k_q),
      .is_signed (signed_q),
      .is64      (is64_q),
      .next_acc  (next_acc),
      .last      (last),
      .ext_value (ext_value)
   );

   assign max_idx = is64_q ? 4'(MAX_LEN64 - 1) : 4'(MAX_LEN32 - 1);

`ifdef LEB128_STRICT_EN
   assign overlong = (k_q == max_idx) && strict_violation(mem_data, signed_q, is64_q);
`else
   assign overlong = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      k_d      = k_q;
      acc_d    = acc_q;
      signed_d = signed_q;
      is64_d   = is64_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      value_d  = value_q;
      length_d = length_q;
      trap_d   = trap_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               signed_d = is_signed;
               is64_d   = is64;
               acc_d    = '0;
               k_d      = '0;
               if (is64 && (USE_64B == 0)) begin
                  // Rejected up front: no ROM access, address left untouched.
                  state_d  = DONE;
                  done_d   = 1'b1;
                  value_d  = '0;
                  length_d = '0;
                  trap_d   = NO_64B;
               end else begin
                  state_d = REQ;
                  busy_d  = 1'b1;
                  addr_d  = start_addr;
               end
            end
         end
         REQ: begin
            state_d = ACC;
            addr_d  = addr_q + 1'b1;
         end
         ACC: begin
            addr_d = addr_q + 1'b1;
            acc_d  = next_acc;
            k_d    = k_q + 4'd1;
            if (mem_error || last || (k_q == max_idx)) begin
               state_d  = DONE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               length_d = k_q + 4'd1;
               value_d  = '0;
               if (mem_error) begin
                  trap_d = MEM_ERROR;
               end else if (!last) begin
                  trap_d = TOO_LONG;
               end else if (overlong) begin
                  trap_d = OVERLONG;
               end else begin
                  trap_d  = NONE;
                  value_d = ext_value;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         k_q      <= '0;
         acc_q    <= '0;
         signed_q <= 1'b0;
         is64_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         value_q  <= '0;
         length_q <= '0;
         trap_q   <= NONE;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         k_q      <= k_d;
         acc_q    <= acc_d;
         signed_q <= signed_d;
         is64_q   <= is64_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         value_q  <= value_d;
         length_q <= length_d;
         trap_q   <= trap_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_extra = '0;
   assign busy      = busy_q;
   assign done      = done_q;
   assign value     = value_q;
   assign length    = length_q;
   assign trap      = trap_q;

endmodule

// File: tb/tb_leb128_decoder.sv
// Scoreboard bench for leb128_decoder: directed encodings in a behavioural ROM, expected
// results queued at start and compared by a monitor when done pulses.
module tb_leb128_decoder;
   import leb128_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [6:0]  start_addr;
   logic        is_signed;
   logic        is64;
   logic [6:0]  mem_addr;
   logic [3:0]  mem_extra;
   logic [7:0]  mem_data;
   logic        mem_error;
   logic        busy, done;
   logic [63:0] value;
   logic [3:0]  length, trap;

   // Second instance built without 64-bit support.
   logic        start0;
   logic [6:0]  start_addr0;
   logic        is_signed0, is64_0;
   logic [7:0]  mem_data0;
   logic        mem_error0;
   logic [6:0]  mem_addr0;
   logic [3:0]  mem_extra0;
   logic        busy0, done0;
   logic [63:0] value0;
   logic [3:0]  length0, trap0;

   logic [7:0]  rom [0:127];
   int          rom_ub = 128;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;

   typedef struct {
      logic [63:0] v;
      logic [3:0]  l;
      logic [3:0]  t;
      int          c;
   } exp_t;
   exp_t sb_q[$];

   leb128_decoder #(.MEM_DEPTH(6), .MEM_EXTRA(4), .USE_64B(1)) dut (
      .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
      .is_signed(is_signed), .is64(is64), .mem_addr(mem_addr), .mem_extra(mem_extra),
      .mem_data(mem_data), .mem_error(mem_error), .busy(busy), .done(done),
      .value(value), .length(length), .trap(trap)
   );

   leb128_decoder #(.MEM_DEPTH(6), .MEM_EXTRA(4), .USE_64B(0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .start_addr(start_addr0),
      .is_signed(is_signed0), .is64(is64_0), .mem_addr(mem_addr0), .mem_extra(mem_extra0),
      .mem_data(mem_data0), .mem_error(mem_error0), .busy(busy0), .done(done0),
      .value(value0), .length(length0), .trap(trap0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      mem_data  <= rom[mem_addr];
      mem_error <= (int'(mem_addr) >= rom_ub);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no pending decode (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            $display("txn cycle=%0d value=%h length=%0d trap=%0d", cyc, value, length, trap);
            chk("value", value, e.v);
            chk("length", 64'(length), 64'(e.l));
            chk("trap", 64'(trap), 64'(e.t));
            chk("done_cycle", 64'(cyc), 64'(e.c));
         end
      end
   end

   task automatic run_vec(input logic [6:0] a, input logic sgn, input logic w64,
                          input logic [63:0] ev, input logic [3:0] el, input logic [3:0] et,
                          input bit poke);
      @(posedge clk); #1;
      start = 1'b1; start_addr = a; is_signed = sgn; is64 = w64;
      @(posedge clk); #1;
      start = 1'b0;
      sb_q.push_back('{ev, el, et, cyc + int'(el) + 1});
      chk("busy_after_start", 64'(busy), 64'd1);
      if (poke) begin
         start = 1'b1; start_addr = 7'd40; is_signed = 1'b0;
         @(posedge clk); #1;
         start = 1'b0; is_signed = sgn;
      end
      for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL done_timeout: got no done expected done for addr %0d", a);
         sb_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 128; i++) rom[i] = 8'h00;
      rom[0]  = 8'hE5; rom[1]  = 8'h8E; rom[2]  = 8'h26;
      rom[4]  = 8'h7F;
      rom[6]  = 8'hC0; rom[7]  = 8'hBB; rom[8]  = 8'h78;
      for (int i = 10; i < 19; i++) rom[i] = 8'hFF;
      rom[19] = 8'h00;
      for (int i = 20; i < 25; i++) rom[i] = 8'h80;
      rom[25] = 8'h00;
      rom[30] = 8'hFF; rom[31] = 8'hFF; rom[32] = 8'hFF; rom[33] = 8'hFF; rom[34] = 8'h7F;
      rom[40] = 8'h02;
      rom[50] = 8'h80; rom[51] = 8'h80; rom[52] = 8'h80;
      rom[70] = 8'h80; rom[71] = 8'h7F;
      rom[80] = 8'h80; rom[81] = 8'h80; rom[82] = 8'h80; rom[83] = 8'h80; rom[84] = 8'h78;
      rom[127] = 8'h81;

      reset = 1'b0; start = 1'b0; start_addr = '0; is_signed = 1'b0; is64 = 1'b0;
      start0 = 1'b0; start_addr0 = '0; is_signed0 = 1'b0; is64_0 = 1'b1;
      mem_data0 = 8'h00; mem_error0 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_value", value, 64'd0);
      chk("rst_length", 64'(length), 64'd0);
      chk("rst_trap", 64'(trap), 64'(NONE));
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_extra", 64'(mem_extra), 64'd0);
      reset = 1'b1;

      run_vec(7'd0,   1'b0, 1'b0, 64'd624485,                4'd3,  NONE,      1'b1);
      run_vec(7'd4,   1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,   4'd1,  NONE,      1'b0);
      run_vec(7'd6,   1'b1, 1'b0, 64'hFFFF_FFFF_FFFE_1DC0,   4'd3,  NONE,      1'b0);
      run_vec(7'd10,  1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF,   4'd10, NONE,      1'b0);
      run_vec(7'd20,  1'b0, 1'b0, 64'd0,                     4'd5,  TOO_LONG,  1'b0);
      run_vec(7'd20,  1'b0, 1'b1, 64'd0,                     4'd6,  NONE,      1'b0);
`ifdef LEB128_STRICT_EN
      run_vec(7'd30,  1'b0, 1'b0, 64'd0,                     4'd5,  OVERLONG,  1'b0);
`else
      run_vec(7'd30,  1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF,   4'd5,  NONE,      1'b0);
`endif
      run_vec(7'd4,   1'b0, 1'b0, 64'h0000_0000_0000_007F,   4'd1,  NONE,      1'b0);
      run_vec(7'd70,  1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80,   4'd2,  NONE,      1'b0);
      run_vec(7'd80,  1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000,   4'd5,  NONE,      1'b0);
      run_vec(7'd127, 1'b0, 1'b0, 64'd79934081,              4'd4,  NONE,      1'b0);
      rom_ub = 51;
      run_vec(7'd50,  1'b0, 1'b0, 64'd0,                     4'd2,  MEM_ERROR, 1'b0);
      rom_ub = 128;

      @(posedge clk); #1;
      start0 = 1'b1; start_addr0 = 7'h55;
      @(posedge clk); #1;
      start0 = 1'b0;
      $display("txn no64b value=%h length=%0d trap=%0d", value0, length0, trap0);
      chk("no64b_done", 64'(done0), 64'd1);
      chk("no64b_trap", 64'(trap0), 64'(NO_64B));
      chk("no64b_length", 64'(length0), 64'd0);
      chk("no64b_value", value0, 64'd0);
      chk("no64b_mem_addr", 64'(mem_addr0), 64'd0);
      chk("no64b_busy", 64'(busy0), 64'd0);
      @(posedge clk); #1;
      chk("no64b_done_pulse", 64'(done0), 64'd0);

      @(posedge clk); #1;
      start = 1'b1; start_addr = 7'd10; is_signed = 1'b1; is64 = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      $display("txn reset_abort busy=%0d done=%0d value=%h", busy, done, value);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_value", value, 64'd0);
      chk("abort_trap", 64'(trap), 64'(NONE));
      chk("abort_mem_addr", 64'(mem_addr), 64'd0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      run_vec(7'd40, 1'b0, 1'b0, 64'd2, 4'd1, NONE, 1'b0);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
